// File: rtl/pipe_pkg.sv
// Shared constants and control types for the CPU pipeline stage registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE_PC = 32'h0000_3000;

  typedef struct packed {
    logic valid;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// One-entry holding register for an instruction/PC pair; clear beats load beats take.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [PC_W-1:0]   d_pc,
  output logic              valid,
  output logic [DATA_W-1:0] q_instr,
  output logic [PC_W-1:0]   q_pc
);

  logic              valid_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [PC_W-1:0]   pc_reg;

  // A load on the same cycle as a take refills the slot with the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= d_instr;
      pc_reg    <= d_pc;
    end else if (take) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid   = valid_reg;
  assign q_instr = instr_reg;
  assign q_pc    = pc_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked inter-stage pipeline register with flush, optional skid slot and
// a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                PC_W         = 32,
  parameter logic [DATA_W-1:0] BUBBLE_INSTR = {DATA_W{1'b0}},
  parameter logic [PC_W-1:0]   RESET_PC     = {PC_W{1'b0}},
  parameter bit                SKID         = 1'b1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_instr_reg;
  logic [PC_W-1:0]   out_pc_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [PC_W-1:0]   skid_pc;

  logic       load_main;
  logic       stalled;
  pipe_ctrl_t in_ctrl;

  assign load_main = !out_valid_reg | out_ready;
  assign stalled   = out_valid_reg & !out_ready;
  assign in_ctrl   = '{valid: in_valid & in_ready, flush: flush};

  generate
    if (SKID) begin : g_skid
      logic skid_load;
      logic skid_take;

      // Accepts go to the slot while the main register is stalled, or when the
      // slot is draining into main this cycle.
      assign skid_load = in_ctrl.valid & (skid_valid | !load_main);
      assign skid_take = load_main & skid_valid;

      pipe_skid_slot #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (in_ctrl.flush),
        .load    (skid_load),
        .take    (skid_take),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .valid   (skid_valid),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
      );

      assign in_ready = !skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_instr = '0;
      assign skid_pc    = '0;
      assign in_ready   = load_main;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= BUBBLE_INSTR;
      out_pc_reg    <= RESET_PC;
    end else if (in_ctrl.flush) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= BUBBLE_INSTR;
      out_pc_reg    <= RESET_PC;
    end else if (load_main) begin
      if (skid_valid) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= skid_instr;
        out_pc_reg    <= skid_pc;
      end else if (in_ctrl.valid) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= in_instr;
        out_pc_reg    <= in_pc;
      end else begin
        // Bubble: PC keeps its last value for debug visibility.
        out_valid_reg <= 1'b0;
        out_instr_reg <= BUBBLE_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stalled && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_pc    = out_pc_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three builds (skid, no skid, 4-bit counter) share one
// stimulus and are checked against a queue model every cycle.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] RPC0 = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        ov [3];
  logic        ir [3];
  logic [31:0] oi [3];
  logic [31:0] op [3];
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  int checks = 0;
  int errors = 0;

  // model: per build, an ordered list of held entries (depth 2 with skid, 1 without)
  int          mcnt  [3];
  logic [31:0] mi    [3][2];
  logic [31:0] mp    [3][2];
  logic [31:0] mlast [3];
  int          msc   [3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.BUBBLE_INSTR(NOP_INSTR), .RESET_PC(RPC0), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_instr(oi[0]), .out_pc(op[0]), .stall_cnt(sc0));

  pipe_stage_reg #(.BUBBLE_INSTR(NOP_INSTR), .RESET_PC(TEXT_BASE_PC), .SKID(1'b0)) u_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_instr(oi[1]), .out_pc(op[1]), .stall_cnt(sc1));

  pipe_stage_reg #(.BUBBLE_INSTR(NOP_INSTR), .RESET_PC(RPC0), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .out_instr(oi[2]), .out_pc(op[2]), .stall_cnt(sc2));

  function automatic logic [15:0] dut_sc(int k);
    if (k == 0) return sc0;
    if (k == 1) return sc1;
    return {12'b0, sc2};
  endfunction

  function automatic logic [31:0] rpc(int k);
    return (k == 1) ? TEXT_BASE_PC : RPC0;
  endfunction

  function automatic int smax(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic m_rdy(int k);
    if (k == 1) return (mcnt[k] == 0) || out_ready;
    return mcnt[k] < 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model update at each rising edge
  initial begin : model_p
    logic acc;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          mcnt[k]  = 0;
          mlast[k] = rpc(k);
          msc[k]   = 0;
        end else begin
          acc = in_valid && m_rdy(k);
          if (mcnt[k] > 0 && !out_ready && msc[k] < smax(k)) msc[k]++;
          if (flush) begin
            mcnt[k]  = 0;
            mlast[k] = rpc(k);
          end else begin
            if (mcnt[k] > 0 && out_ready) begin
              mi[k][0] = mi[k][1];
              mp[k][0] = mp[k][1];
              mcnt[k]--;
            end
            if (acc) begin
              mi[k][mcnt[k]] = in_instr;
              mp[k][mcnt[k]] = in_pc;
              mcnt[k]++;
            end
            if (mcnt[k] > 0) mlast[k] = mp[k][0];
          end
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin : compare_p
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("u%0d out_valid", k), ov[k], (mcnt[k] > 0));
          chk($sformatf("u%0d out_instr", k), oi[k], (mcnt[k] > 0) ? mi[k][0] : NOP_INSTR);
          chk($sformatf("u%0d out_pc", k), op[k], mlast[k]);
          chk($sformatf("u%0d in_ready", k), ir[k], m_rdy(k));
          chk($sformatf("u%0d stall_cnt", k), dut_sc(k), msc[k]);
        end
      end
    end
  end

  initial begin : stim_p
    logic [31:0] pc;
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset u0 out_valid", ov[0], 0);
    chk("reset u0 out_pc", op[0], RPC0);
    chk("reset u0 in_ready", ir[0], 1);
    chk("reset u1 out_pc", op[1], TEXT_BASE_PC);

    // streaming, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h2000_0000 + i, 32'h3000 + 4 * i, 1, 0);
      chk("stream u0 in_ready", ir[0], 1);
      tick();
      chk("stream u0 out_pc", op[0], 32'h3000 + 4 * i);
      chk("stream u0 out_instr", oi[0], 32'h2000_0000 + i);
      chk("stream u1 out_pc", op[1], 32'h3000 + 4 * i);
    end
    drive(0, 0, 0, 1, 0);
    tick();
    chk("stream drain out_valid", ov[0], 0);
    chk("stream drain out_pc hold", op[0], 32'h300C);
    chk("stream stall_cnt", sc0, 0);

    // stall with skid
    drive(1, 32'hA0, 32'h3000, 1, 0); tick();
    drive(1, 32'hA1, 32'h3004, 0, 0); tick();
    chk("skid in_ready drop", ir[0], 0);
    drive(1, 32'hA2, 32'h3008, 0, 0); tick(); tick();
    chk("skid held pc", op[0], 32'h3000);
    chk("skid stall_cnt", sc0, 3);
    drive(1, 32'hA2, 32'h3008, 1, 0); tick();
    chk("skid release pc1", op[0], 32'h3004);
    chk("skid release instr1", oi[0], 32'hA1);
    tick();
    chk("skid release pc2", op[0], 32'h3008);
    chk("skid release instr2", oi[0], 32'hA2);
    drive(0, 0, 0, 1, 0); tick();

    // flush during stall
    drive(1, 32'hB0, 32'h3000, 1, 0); tick();
    drive(1, 32'hB1, 32'h3004, 0, 0); tick();
    drive(1, 32'hB2, 32'h3008, 0, 1); tick();
    chk("flush out_valid", ov[0], 0);
    chk("flush out_instr", oi[0], NOP_INSTR);
    chk("flush out_pc", op[0], RPC0);
    chk("flush in_ready", ir[0], 1);
    drive(0, 0, 0, 1, 0);
    repeat (3) begin
      tick();
      chk("flush no leak", ov[0], 0);
    end

    // no-skid build: combinational in_ready and back-to-back transfer
    drive(1, 32'hC0, 32'h3000, 1, 0); tick();
    drive(1, 32'hC1, 32'h3004, 0, 0); #1;
    chk("noskid in_ready stall", ir[1], 0);
    tick();
    chk("noskid held pc", op[1], 32'h3000);
    drive(1, 32'hC1, 32'h3004, 1, 0); #1;
    chk("noskid in_ready go", ir[1], 1);
    tick();
    chk("noskid pc1", op[1], 32'h3004);
    drive(1, 32'hC2, 32'h3008, 1, 0); tick();
    chk("noskid b2b valid", ov[1], 1);
    chk("noskid b2b pc", op[1], 32'h3008);
    drive(0, 0, 0, 1, 0); tick();

    // counter saturation
    drive(1, 32'hD0, 32'h3000, 1, 0); tick();
    drive(0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("sat stall_cnt", sc2, 4'hF);
    drive(0, 0, 0, 0, 1); tick();
    chk("sat after flush", sc2, 4'hF);
    drive(0, 0, 0, 1, 0); tick();

    // asynchronous reset mid-stream
    drive(1, 32'h2408_0005, 32'h3010, 1, 0); tick();
    chk("areset pre valid", ov[0], 1);
    chk("areset pre instr", oi[0], 32'h2408_0005);
    drive(0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("areset out_valid", ov[0], 0);
    chk("areset out_instr", oi[0], NOP_INSTR);
    chk("areset out_pc", op[0], RPC0);
    chk("areset stall_cnt", sc0, 0);
    chk("areset in_ready", ir[0], 1);
    tick(); tick();
    reset = 1'b0;

    // randomized traffic
    pc = 32'h0001_0000;
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 70, $urandom, pc,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      pc = pc + 32'd4;
      tick();
    end
    drive(0, 0, 0, 1, 0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register for the 5-stage CPU. It replaces the fixed 32-bit enable-only inter-stage registers (F/D, D/E, E/M, M/W).
- Carries an instruction word and PC with a valid bit, using valid/ready flow control instead of a bare enable.
- Supports synchronous flush to a bubble and an optional one-entry skid slot, so upstream ready is registered.
- Provides a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 32, instruction/payload width in bits.
- PC_W, 32, PC width in bits.
- BUBBLE_INSTR, {DATA_W{1'b0}}, value driven on out_instr when out_valid=0 (NOP).
- RESET_PC, {PC_W{1'b0}}, value of out_pc after reset and flush.
- SKID, 1, 1 = one-entry skid slot with registered in_ready; 0 = no skid, combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  DATA_W  upstream instruction.
- in_pc  in  PC_W  upstream PC.
- flush  in  1  synchronous kill of all held contents (branch/exception).
- out_valid  out  1  out_instr/out_pc hold a live instruction.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_instr  out  DATA_W  held instruction; BUBBLE_INSTR when invalid.
- out_pc  out  PC_W  held PC.
- stall_cnt  out  CNT_W  cycles where out_valid=1 and out_ready=0.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_instr=BUBBLE_INSTR, out_pc=RESET_PC.
  - Skid slot empty, stall_cnt=0.
  - in_ready=1 while reset is high and after it is released.
- Transfer definitions: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when the stage is not stalled. Throughput is 1 per cycle.
- Main register load condition: load when !out_valid | out_ready.
  - Source is the skid slot if it is valid, else the input (if accept).
  - If nothing is available to load, out_valid becomes 0 and out_instr=BUBBLE_INSTR. out_pc holds its last value.
- SKID=1:
  - in_ready = !skid_valid, driven from a register.
  - An accept while the main register is valid and out_ready=0 writes the skid slot; in_ready drops the following cycle.
  - When the main register loads from the skid slot, the skid slot takes that same cycle's accept (if any) or becomes empty.
- SKID=0:
  - in_ready = !out_valid | out_ready, combinational. No skid storage.
- Ordering: instructions leave in acceptance order. None is dropped, duplicated or reordered, except by flush.
- flush=1 (highest priority, synchronous):
  - Next cycle: out_valid=0, out_instr=BUBBLE_INSTR, out_pc=RESET_PC, skid empty.
  - An accept in the same cycle completes the handshake upstream, but its data is discarded.
  - in_ready=1 next cycle.
- Simultaneous flush and stall: flush wins.
- Simultaneous retire and accept: the main register takes the new data. No bubble is inserted.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all-ones and does not wrap.
  - Unaffected by flush; cleared only by reset.
- All outputs change only on clk edges, except in_ready when SKID=0.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INSTR (32'h0000_0000) and TEXT_BASE_PC constants, used as BUBBLE_INSTR/RESET_PC defaults at instantiation.
  - a pipe_ctrl_t struct {valid, flush}.
- One sub-module: pipe_skid_slot. It is a one-entry DATA_W+PC_W holding register with valid, load, take and clear. It is instantiated only under SKID=1 via generate.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1, out_instr=32'h2408_0005 -> out_valid=0, out_instr=0, out_pc=RESET_PC, stall_cnt=0 immediately, without waiting for a clk edge.
- Streaming: in_valid=1 for 4 cycles, PCs 0x3000/0x3004/0x3008/0x300C, out_ready=1 -> each appears exactly 1 cycle later, in_ready stays 1, stall_cnt=0.
- Stall with skid (SKID=1):
  - Stimulus: hold out_ready=0 for 3 cycles while sending 0x3000, 0x3004, 0x3008.
  - Response: 0x3000 held on the outputs, 0x3004 in the skid slot, in_ready=0 from the next cycle, 0x3008 not accepted. stall_cnt=3.
  - On release, 0x3004 then 0x3008 emerge in order.
- Flush during stall: main holds 0x3000 and skid holds 0x3004; assert flush=1 with in_valid=1 (0x3008) -> next cycle out_valid=0, out_instr=BUBBLE_INSTR, skid empty, in_ready=1. 0x3008 never appears.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with simultaneous accept -> back-to-back transfer with no bubble.
- Counter saturation (CNT_W=4): stall 20 cycles -> stall_cnt reaches 4'hF and holds. A flush leaves it at 4'hF.
